ifc_rr_scheduler: RTL and testbench
===================================

Name: ifc_rr_scheduler

Overview:
- Shares one combinational interface-datapath unit among NREQ requesters.
- Each requester presents an operand bundle (A, B, X, Y, Q); a round-robin arbiter grants one requester at a time and registers its operands into the shared unit.
- The 8-bit Z result is captured and returned on a single tagged response channel with valid/ready handshake.
- Sits between requester ports and the shared datapath, in the same design layer as the interface entities it drives.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID = clog2(NREQ)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- REQ_VALID  in  NREQ  per-requester request valid
- REQ_READY  out  NREQ  per-requester accept strobe, one-hot or zero
- REQ_A  in  NREQ x 8  operand A per requester
- REQ_B  in  NREQ x 8  operand B per requester
- REQ_X  in  NREQ x 16  interface field X per requester
- REQ_Y  in  NREQ x 16  interface field Y per requester
- REQ_Q  in  NREQ x 8  interface field Q per requester
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response consumer ready
- RSP_ID  out  IDW  index of the requester that owns the response
- RSP_Z  out  8  result Z
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge):
  - state=IDLE, round-robin pointer PTR=0
  - operand regs, RSP_Z and RSP_ID are 0; RSP_VALID=0, BUSY=0, REQ_READY=0
  - any in-flight operation is discarded with no response
  - RST dominates every other input in the same cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner W is the first i with REQ_VALID[i]=1, searching PTR, PTR+1, ... mod NREQ.
  - If a winner exists: REQ_READY[W]=1 combinationally in that cycle (a handshake occurs in that cycle); latch A, B, X, Y, Q and ID=W; go to EXEC.
  - If none: stay in IDLE with REQ_READY=0.
- EXEC (one cycle):
  - The shared datapath evaluates Z from the latched operands.
  - Register Z into RSP_Z; set RSP_VALID=1; go to RESP.
- RESP:
  - Hold RSP_VALID, RSP_ID and RSP_Z stable until RSP_READY=1.
  - On the handshake cycle: PTR <= (ID+1) mod NREQ; go to IDLE; RSP_VALID=0 from the next cycle.
  - REQ_READY stays 0 throughout EXEC and RESP.
- Latency: request accept to RSP_VALID = 2 cycles. Peak throughput is 1 operation per 3 cycles with RSP_READY held high.
- Datapath arithmetic, all unsigned:
  - S = (X + Y) mod 2^16
  - D = (S - zext16(Q)) mod 2^16
  - L = zext16((A & B) | (A ^ B))
  - Z = (L | D)[7:0], i.e. truncated to 8 bits
  - No saturation: wrap-around is intentional.
- Fairness: a requester that holds REQ_VALID continuously is granted within NREQ grants.
- Requesters may drop REQ_VALID before being granted; no state is kept for them.
- Simultaneous RSP_READY handshake and new REQ_VALID: the new request is not examined until the cycle after returning to IDLE, so there is no same-cycle reissue.
- RSP_READY is ignored outside RESP.
- REQ_* changes after the grant do not affect the in-flight result (operands are latched).

Decomposition:
- Shared package ifc_sched_pkg:
  - state enum {IDLE, EXEC, RESP}
  - operand struct {a 8, b 8, x 16, y 16, q 8}
  - function rr_pick(valid vector, ptr) returning {found, index}
  - width constants (A/B/Q = 8, X/Y = 16, Z = 8)
- One sub-module, ifc_datapath: purely combinational, inputs A, B, X, Y, Q, output Z, implementing the arithmetic above. It is instantiated once inside ifc_rr_scheduler.

Test Plan:
- Single request: req0 with A=0x01, B=0x02, X=17, Y=21, Q=3 -> REQ_READY[0] pulses in the request cycle; 2 cycles later RSP_VALID=1, RSP_ID=0, RSP_Z=0x23.
- Wrap-around: X=0xFFFF, Y=2, Q=0, A=B=0 -> RSP_Z=0x01. With X=0, Y=0, Q=1, A=B=0 -> RSP_Z=0xFF.
- Round-robin: all 4 REQ_VALID held high, RSP_READY=1 -> grants in order 0, 1, 2, 3, 0, each spaced 3 cycles apart, with RSP_ID matching.
- Backpressure: RSP_READY=0 for 5 cycles in RESP -> RSP_VALID, RSP_ID and RSP_Z stable, REQ_READY all 0, BUSY=1. When RSP_READY=1 -> RSP_VALID=0 the next cycle and IDLE resumes.
- Reset mid-operation: assert RST in EXEC -> next cycle RSP_VALID=0, BUSY=0, PTR=0; no response is ever issued for the discarded request; the next grant goes to the lowest valid index.
- Pointer skip: only req2 valid after a grant to req0 -> req2 granted next. Then req1 and req3 both valid -> req3 granted before req1.

Source files
------------

// File: rtl/ifc_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | ifc_sched_pkg: shared types, widths and round-robin pick for the scheduler |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package ifc_sched_pkg;

  localparam int c_AB_W    = 8;
  localparam int c_XY_W    = 16;
  localparam int c_Q_W     = 8;
  localparam int c_Z_W     = 8;
  localparam int c_MAX_REQ = 8;
  localparam int c_MAX_IDW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [c_AB_W-1:0] a;
    logic [c_AB_W-1:0] b;
    logic [c_XY_W-1:0] x;
    logic [c_XY_W-1:0] y;
    logic [c_Q_W-1:0]  q;
  } operand_t;

  typedef struct packed {
    logic                 found;
    logic [c_MAX_IDW-1:0] idx;
  } pick_t;

  // First asserted bit searching ptr, ptr+1, ... modulo n (n <= c_MAX_REQ).
  function automatic pick_t rr_pick(input logic [c_MAX_REQ-1:0] valid,
                                    input logic [c_MAX_IDW-1:0] ptr,
                                    input int                   n);
    pick_t                r;
    logic [c_MAX_IDW-1:0] cand;
    r = '0;
    for (int k = 0; k < c_MAX_REQ; k++) begin
      cand = c_MAX_IDW'((int'(ptr) + k) % n);
      if (k < n && !r.found && valid[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifc_datapath.sv
// +----------------------------------------------------------------------------+
// | ifc_datapath: combinational interface datapath, Z = ((A|B) | (X+Y-Q))[7:0] |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifc_datapath
  import ifc_sched_pkg::*;
(
  input  logic [c_AB_W-1:0] A,
  input  logic [c_AB_W-1:0] B,
  input  logic [c_XY_W-1:0] X,
  input  logic [c_XY_W-1:0] Y,
  input  logic [c_Q_W-1:0]  Q,
  output logic [c_Z_W-1:0]  Z
);

  logic [c_XY_W-1:0] w_s;
  logic [c_XY_W-1:0] w_d;
  logic [c_XY_W-1:0] w_l;
  logic [c_XY_W-1:0] w_zfull;

  // All sums wrap modulo 2^16 by construction of the 16-bit operands.
  assign w_s     = X + Y;
  assign w_d     = w_s - c_XY_W'(Q);
  assign w_l     = c_XY_W'((A & B) | (A ^ B));
  assign w_zfull = w_l | w_d;
  assign Z       = w_zfull[c_Z_W-1:0];

endmodule

`default_nettype wire

// File: rtl/ifc_rr_scheduler.sv
// +----------------------------------------------------------------------------+
// | ifc_rr_scheduler: round-robin sharing of one ifc_datapath among NREQ ports |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifc_rr_scheduler
  import ifc_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NREQ-1:0]               REQ_VALID,
  output logic [NREQ-1:0]               REQ_READY,
  input  logic [NREQ-1:0][c_AB_W-1:0]   REQ_A,
  input  logic [NREQ-1:0][c_AB_W-1:0]   REQ_B,
  input  logic [NREQ-1:0][c_XY_W-1:0]   REQ_X,
  input  logic [NREQ-1:0][c_XY_W-1:0]   REQ_Y,
  input  logic [NREQ-1:0][c_Q_W-1:0]    REQ_Q,
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic [IDW-1:0]                RSP_ID,
  output logic [c_Z_W-1:0]              RSP_Z,
  output logic                          BUSY
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_win;
  operand_t         r_op;
  logic [c_Z_W-1:0] r_rsp_z;
  logic [c_Z_W-1:0] w_z;
  logic             r_rsp_valid;
  pick_t            w_pick;
  logic             w_accept;
  logic             w_rsp_hs;

  assign w_pick = rr_pick(c_MAX_REQ'(REQ_VALID), c_MAX_IDW'(r_ptr), NREQ);
  assign w_win  = IDW'(w_pick.idx);

  always_comb begin
    w_state_nxt = r_state;
    REQ_READY   = '0;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          REQ_READY[w_win] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (RSP_READY) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operands are latched at grant so requester changes cannot disturb the result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_op        <= '0;
      r_rsp_z     <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= '{a: REQ_A[w_win], b: REQ_B[w_win], x: REQ_X[w_win],
                  y: REQ_Y[w_win], q: REQ_Q[w_win]};
        r_id <= w_win;
      end
      if (r_state == EXEC) begin
        r_rsp_z     <= w_z;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_ptr       <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
      end
    end
  end

  ifc_datapath u_datapath (
    .A (r_op.a),
    .B (r_op.b),
    .X (r_op.x),
    .Y (r_op.y),
    .Q (r_op.q),
    .Z (w_z)
  );

  assign RSP_VALID = r_rsp_valid;
  assign RSP_ID    = r_id;
  assign RSP_Z     = r_rsp_z;
  assign BUSY      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ifc_rr_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_ifc_rr_scheduler: directed self-checking bench for ifc_rr_scheduler     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ifc_rr_scheduler;

  logic             CLK = 1'b0;
  logic             RST;
  logic [3:0]       REQ_VALID;
  logic [3:0]       REQ_READY;
  logic [3:0][7:0]  REQ_A;
  logic [3:0][7:0]  REQ_B;
  logic [3:0][15:0] REQ_X;
  logic [3:0][15:0] REQ_Y;
  logic [3:0][7:0]  REQ_Q;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [1:0]       RSP_ID;
  logic [7:0]       RSP_Z;
  logic             BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  ifc_rr_scheduler #(.NREQ(4), .IDW(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_X     (REQ_X),
    .REQ_Y     (REQ_Y),
    .REQ_Q     (REQ_Q),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_ID    (RSP_ID),
    .RSP_Z     (RSP_Z),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] x, input logic [15:0] y, input logic [7:0] q);
    REQ_A[i] = a;
    REQ_B[i] = b;
    REQ_X[i] = x;
    REQ_Y[i] = y;
    REQ_Q[i] = q;
  endtask

  // Single isolated operation from requester i, returning to IDLE afterwards.
  task automatic do_op(input string tag, input int i, input logic [7:0] exp_z);
    REQ_VALID = 4'(1 << i);
    #1;
    chk({tag, "_ready"}, 32'(REQ_READY), 32'(1 << i));
    tick();
    REQ_VALID = 4'b0000;
    chk({tag, "_exec_valid"}, 32'(RSP_VALID), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(RSP_VALID), 32'd1);
    chk({tag, "_id"}, 32'(RSP_ID), 32'(i));
    chk({tag, "_z"}, 32'(RSP_Z), 32'(exp_z));
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk({tag, "_done_valid"}, 32'(RSP_VALID), 32'd0);
    chk({tag, "_done_busy"}, 32'(BUSY), 32'd0);
  endtask

  logic [7:0] rr_z [4] = '{8'h11, 8'h01, 8'h80, 8'h0F};

  initial begin
    RST       = 1'b1;
    REQ_VALID = '0;
    RSP_READY = 1'b0;
    REQ_A = '0; REQ_B = '0; REQ_X = '0; REQ_Y = '0; REQ_Q = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_busy",  32'(BUSY),      32'd0);
    chk("rst_ready", 32'(REQ_READY), 32'd0);
    chk("rst_z",     32'(RSP_Z),     32'd0);
    chk("rst_id",    32'(RSP_ID),    32'd0);

    // Single request from req0 held in RESP under backpressure.
    set_req(0, 8'h01, 8'h02, 16'd17, 16'd21, 8'd3);
    REQ_VALID = 4'b0001;
    #1;
    chk("single_ready", 32'(REQ_READY), 32'b0001);
    chk("single_idle_busy", 32'(BUSY), 32'd0);
    tick();
    REQ_VALID = 4'b0000;
    chk("single_exec_busy", 32'(BUSY), 32'd1);
    chk("single_exec_valid", 32'(RSP_VALID), 32'd0);
    tick();
    chk("single_valid", 32'(RSP_VALID), 32'd1);
    chk("single_id", 32'(RSP_ID), 32'd0);
    chk("single_z", 32'(RSP_Z), 32'h23);
    REQ_VALID = 4'b1111;
    REQ_A[0]  = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", 32'(RSP_VALID), 32'd1);
      chk("bp_id",    32'(RSP_ID),    32'd0);
      chk("bp_z",     32'(RSP_Z),     32'h23);
      chk("bp_ready", 32'(REQ_READY), 32'd0);
      chk("bp_busy",  32'(BUSY),      32'd1);
    end
    REQ_VALID = 4'b0000;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk("bp_release_valid", 32'(RSP_VALID), 32'd0);
    chk("bp_release_busy",  32'(BUSY),      32'd0);

    // Wrap-around arithmetic (pointer now 1, then 2).
    set_req(1, 8'h00, 8'h00, 16'hFFFF, 16'd2, 8'd0);
    do_op("wrap_add", 1, 8'h01);
    set_req(2, 8'h00, 8'h00, 16'd0, 16'd0, 8'd1);
    do_op("wrap_sub", 2, 8'hFF);

    // Pointer skip: req0, then only req2, then req1+req3 -> req3 first.
    set_req(0, 8'h10, 8'h01, 16'h0100, 16'h0020, 8'h0F);
    do_op("skip_r0", 0, 8'h11);
    set_req(2, 8'h80, 8'h00, 16'h1234, 16'h1111, 8'h45);
    do_op("skip_r2", 2, 8'h80);
    set_req(3, 8'h05, 8'h0A, 16'h0100, 16'h0000, 8'h00);
    REQ_VALID = 4'b1010;
    #1;
    chk("skip_r3_first", 32'(REQ_READY), 32'b1000);
    tick();
    tick();
    chk("skip_r3_id", 32'(RSP_ID), 32'd3);
    chk("skip_r3_z",  32'(RSP_Z),  32'h0F);
    RSP_READY = 1'b1;
    #1;
    chk("skip_hs_no_reissue", 32'(REQ_READY), 32'd0);
    tick();
    RSP_READY = 1'b0;
    chk("skip_r1_next", 32'(REQ_READY), 32'b0010);
    tick();
    REQ_VALID = 4'b0000;
    tick();
    chk("skip_r1_id", 32'(RSP_ID), 32'd1);
    chk("skip_r1_z",  32'(RSP_Z),  32'h01);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;

    // Reset while req2 is in EXEC (pointer is 2 beforehand).
    REQ_VALID = 4'b0100;
    #1;
    chk("rstmid_ready", 32'(REQ_READY), 32'b0100);
    tick();
    REQ_VALID = 4'b0000;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstmid_valid", 32'(RSP_VALID), 32'd0);
    chk("rstmid_busy",  32'(BUSY),      32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rstmid_no_rsp", 32'(RSP_VALID), 32'd0);
    end

    // Round-robin with all requesters valid, starting from the reset pointer.
    REQ_VALID = 4'b1111;
    RSP_READY = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_grant", 32'(REQ_READY), 32'(1 << (g % 4)));
      tick();
      chk("rr_exec_ready", 32'(REQ_READY), 32'd0);
      tick();
      chk("rr_valid", 32'(RSP_VALID), 32'd1);
      chk("rr_id", 32'(RSP_ID), 32'(g % 4));
      chk("rr_z", 32'(RSP_Z), 32'(rr_z[g % 4]));
      tick();
    end
    REQ_VALID = 4'b0000;
    RSP_READY = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
